hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_pkg.sv | 23 ++
 rtl/hazard_sb_entry.sv | 46 ++++
 rtl/rvseed_defines.sv | 13 +
 rtl/hazard_scoreboard.sv | 79 +++++++
 tb/tb_hazard_scoreboard.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Types and constants shared by the hazard scoreboard and its per-register entries.
`ifndef RVSEED_DEFINES_SV
`define RVSEED_DEFINES_SV
`define REG_ADDR_WIDTH  5
`define ISSUE_KIND_ALU  2'd0
`define ISSUE_KIND_LOAD 2'd1
`define ISSUE_KIND_LONG 2'd2
`define ISSUE_KIND_RSVD 2'd3
`endif

package hazard_scoreboard_pkg;

    localparam int unsigned REG_AW = `REG_ADDR_WIDTH;
    localparam int unsigned NREGS  = 32;

    typedef enum logic [1:0] {
        KIND_ALU  = `ISSUE_KIND_ALU,
        KIND_LOAD = `ISSUE_KIND_LOAD,
        KIND_LONG = `ISSUE_KIND_LONG,
        KIND_RSVD = `ISSUE_KIND_RSVD
    } issue_kind_e;

endpackage

// File: rtl/hazard_sb_entry.sv
// One architectural register's hazard state: a latency countdown plus a long-op flag.
module hazard_sb_entry
    import hazard_scoreboard_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             load,
    input  logic [CNT_W-1:0] load_cnt,
    input  logic             load_long,
    input  logic             wb_clr,
    output logic             pending
);

    logic [CNT_W-1:0] cnt;
    logic             long_op;

    // Priority: flush, then a new producer, then countdown and long-op completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            long_op <= 1'b0;
        end else if (flush) begin
            cnt     <= '0;
            long_op <= 1'b0;
        end else if (load) begin
            cnt     <= load_cnt;
            long_op <= load_long;
        end else begin
            if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (wb_clr) begin
                long_op <= 1'b0;
            end
        end
    end

    // Pending is a pure decode of the registered state.
    always_comb begin
        pending = (cnt != '0) | long_op;
    end

endmodule

// File: rtl/rvseed_defines.sv
// Shared RV-seed core defines: register index width and issue_kind producer codes.
`ifndef RVSEED_DEFINES_SV
`define RVSEED_DEFINES_SV

`define REG_ADDR_WIDTH  5

// Producer class codes carried on issue_kind; code 3 is reserved and behaves as ALU.
`define ISSUE_KIND_ALU  2'd0
`define ISSUE_KIND_LOAD 2'd1
`define ISSUE_KIND_LONG 2'd2
`define ISSUE_KIND_RSVD 2'd3

`endif

// File: rtl/hazard_scoreboard.sv
// Decode-stage RAW hazard scoreboard: tracks in-flight producers per register and stalls ID.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NRD     = 2,
    parameter int ALU_LAT = 0,
    parameter int LD_LAT  = 2,
    parameter int CNT_W   = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NRD-1:0]                  src_en,
    input  logic [NRD*`REG_ADDR_WIDTH-1:0]  src_addr,
    input  logic                            issue_fire,
    input  logic                            issue_we,
    input  logic [`REG_ADDR_WIDTH-1:0]      issue_rd,
    input  logic [1:0]                      issue_kind,
    input  logic                            wb_valid,
    input  logic [`REG_ADDR_WIDTH-1:0]      wb_rd,
    input  logic                            flush,
    output logic                            stall,
    output logic [31:0]                     pend_mask
);

    if ((ALU_LAT >= (1 << CNT_W)) || (LD_LAT >= (1 << CNT_W))) begin : g_cnt_w_check
        $error("hazard_scoreboard: CNT_W too narrow for ALU_LAT/LD_LAT");
    end

    logic             issue_hit;
    logic [CNT_W-1:0] issue_cnt;
    logic             issue_long;
    logic [REG_AW-1:0] rd_addr;

    // Decode the issuing producer into the countdown/long-op values to load.
    always_comb begin
        issue_hit  = issue_fire & issue_we & (issue_rd != '0);
        issue_cnt  = CNT_W'(ALU_LAT);
        issue_long = 1'b0;
        case (issue_kind_e'(issue_kind))
            KIND_LOAD: issue_cnt = CNT_W'(LD_LAT);
            KIND_LONG: begin
                issue_cnt  = '0;
                issue_long = 1'b1;
            end
            default:   issue_cnt = CNT_W'(ALU_LAT);
        endcase
    end

    // x0 is hardwired, so it never has an entry and is never pending.
    assign pend_mask[0] = 1'b0;

    for (genvar r = 1; r < NREGS; r++) begin : g_entry
        hazard_sb_entry #(
            .CNT_W (CNT_W)
        ) u_entry (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .load      (issue_hit && (issue_rd == REG_AW'(r))),
            .load_cnt  (issue_cnt),
            .load_long (issue_long),
            .wb_clr    (wb_valid && (wb_rd == REG_AW'(r))),
            .pending   (pend_mask[r])
        );
    end

    // Stall when any enabled source port reads a pending register.
    always_comb begin
        stall   = 1'b0;
        rd_addr = '0;
        for (int unsigned p = 0; p < NRD; p++) begin
            rd_addr = src_addr[p*REG_AW +: REG_AW];
            if (src_en[p] && (rd_addr != '0) && pend_mask[rd_addr]) begin
                stall = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed table-driven bench for hazard_scoreboard with default latencies (ALU 0, LOAD 2).
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int AW = `REG_ADDR_WIDTH;
    localparam logic [1:0] K_ALU  = 2'd0;
    localparam logic [1:0] K_LOAD = 2'd1;
    localparam logic [1:0] K_LONG = 2'd2;
    localparam logic [1:0] K_RSVD = 2'd3;

    logic            clk;
    logic            rst_n;
    logic [1:0]      src_en;
    logic [2*AW-1:0] src_addr;
    logic            issue_fire;
    logic            issue_we;
    logic [AW-1:0]   issue_rd;
    logic [1:0]      issue_kind;
    logic            wb_valid;
    logic [AW-1:0]   wb_rd;
    logic            flush;
    logic            stall;
    logic [31:0]     pend_mask;

    int compared;
    int mismatched;

    hazard_scoreboard #(
        .NRD     (2),
        .ALU_LAT (0),
        .LD_LAT  (2),
        .CNT_W   (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .src_en     (src_en),
        .src_addr   (src_addr),
        .issue_fire (issue_fire),
        .issue_we   (issue_we),
        .issue_rd   (issue_rd),
        .issue_kind (issue_kind),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .flush      (flush),
        .stall      (stall),
        .pend_mask  (pend_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    en;
        logic [AW-1:0] s1;
        logic [AW-1:0] s0;
        logic          fire;
        logic          we;
        logic [AW-1:0] rd;
        logic [1:0]    kind;
        logic          wbv;
        logic [AW-1:0] wbrd;
        logic          fl;
        logic          es;
        logic [31:0]   ep;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic [1:0] en, int s1, int s0, logic fire, logic we, int rd,
                                logic [1:0] kind, logic wbv, int wbrd, logic fl,
                                logic es, logic [31:0] ep);
        vec_t v;
        v.en = en; v.s1 = AW'(s1); v.s0 = AW'(s0);
        v.fire = fire; v.we = we; v.rd = AW'(rd); v.kind = kind;
        v.wbv = wbv; v.wbrd = AW'(wbrd); v.fl = fl;
        v.es = es; v.ep = ep;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] en, input int s1, input int s0, input logic fire,
                         input logic we, input int rd, input logic [1:0] kind,
                         input logic wbv, input int wbrd, input logic fl);
        src_en     = en;
        src_addr   = {AW'(s1), AW'(s0)};
        issue_fire = fire;
        issue_we   = we;
        issue_rd   = AW'(rd);
        issue_kind = kind;
        wb_valid   = wbv;
        wb_rd      = AW'(wbrd);
        flush      = fl;
    endtask

    task automatic idle_src(input int s);
        drive(2'b01, 0, s, 1'b0, 1'b0, 0, K_ALU, 1'b0, 0, 1'b0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;

        //        en    s1 s0  fire we rd kind    wbv wbrd fl  stall pend
        vt.push_back(mk(2'b11, 5, 6,  0, 0, 0, K_ALU,  0, 0,  0, 0, 32'h0));
        vt.push_back(mk(2'b11, 5, 6,  1, 1, 5, K_LOAD, 0, 0,  0, 0, 32'h0));
        vt.push_back(mk(2'b11, 5, 6,  0, 0, 0, K_ALU,  0, 0,  0, 1, 32'h20));
        vt.push_back(mk(2'b11, 5, 6,  0, 0, 0, K_ALU,  0, 0,  0, 1, 32'h20));
        vt.push_back(mk(2'b11, 5, 6,  0, 0, 0, K_ALU,  0, 0,  0, 0, 32'h0));
        vt.push_back(mk(2'b01, 0, 7,  1, 1, 7, K_ALU,  0, 0,  0, 0, 32'h0));
        vt.push_back(mk(2'b01, 0, 7,  0, 0, 0, K_ALU,  0, 0,  0, 0, 32'h0));
        vt.push_back(mk(2'b01, 0, 9,  1, 1, 9, K_LONG, 0, 0,  0, 0, 32'h0));
        vt.push_back(mk(2'b10, 9, 0,  0, 0, 0, K_ALU,  0, 0,  0, 1, 32'h200));
        vt.push_back(mk(2'b00, 9, 9,  0, 0, 0, K_ALU,  0, 0,  0, 0, 32'h200));
        vt.push_back(mk(2'b01, 0, 9,  0, 0, 0, K_ALU,  1, 9,  0, 1, 32'h200));
        vt.push_back(mk(2'b01, 0, 9,  0, 0, 0, K_ALU,  0, 0,  0, 0, 32'h0));
        vt.push_back(mk(2'b01, 0, 3,  1, 1, 3, K_LOAD, 1, 9,  0, 0, 32'h0));
        vt.push_back(mk(2'b01, 0, 3,  0, 0, 0, K_ALU,  1, 3,  0, 1, 32'h8));
        vt.push_back(mk(2'b01, 0, 3,  0, 0, 0, K_ALU,  0, 0,  0, 1, 32'h8));
        vt.push_back(mk(2'b01, 0, 3,  0, 0, 0, K_ALU,  0, 0,  0, 0, 32'h0));
        vt.push_back(mk(2'b01, 0, 3,  1, 1, 3, K_LOAD, 0, 0,  0, 0, 32'h0));
        vt.push_back(mk(2'b01, 0, 3,  0, 0, 0, K_ALU,  0, 0,  1, 1, 32'h8));
        vt.push_back(mk(2'b01, 0, 3,  0, 0, 0, K_ALU,  0, 0,  0, 0, 32'h0));
        vt.push_back(mk(2'b01, 0, 4,  1, 1, 4, K_LONG, 0, 0,  0, 0, 32'h0));
        vt.push_back(mk(2'b01, 0, 4,  1, 1, 4, K_LONG, 1, 4,  0, 1, 32'h10));
        vt.push_back(mk(2'b01, 0, 4,  0, 0, 0, K_ALU,  0, 0,  0, 1, 32'h10));
        vt.push_back(mk(2'b01, 0, 4,  1, 1, 4, K_ALU,  0, 0,  0, 1, 32'h10));
        vt.push_back(mk(2'b01, 0, 4,  0, 0, 0, K_ALU,  0, 0,  0, 0, 32'h0));
        vt.push_back(mk(2'b11, 0, 0,  1, 1, 0, K_LOAD, 0, 0,  0, 0, 32'h0));
        vt.push_back(mk(2'b11, 0, 0,  0, 0, 0, K_ALU,  0, 0,  0, 0, 32'h0));
        vt.push_back(mk(2'b01, 0, 8,  1, 1, 8, K_LOAD, 0, 0,  1, 0, 32'h0));
        vt.push_back(mk(2'b01, 0, 8,  0, 0, 0, K_ALU,  0, 0,  0, 0, 32'h0));
        vt.push_back(mk(2'b01, 0, 10, 1, 1, 10, K_LOAD, 0, 0, 0, 0, 32'h0));
        vt.push_back(mk(2'b01, 0, 10, 1, 1, 10, K_ALU,  0, 0, 0, 1, 32'h400));
        vt.push_back(mk(2'b01, 0, 10, 0, 0, 0, K_ALU,  0, 0,  0, 0, 32'h0));
        vt.push_back(mk(2'b01, 0, 11, 1, 1, 11, K_RSVD, 0, 0, 0, 0, 32'h0));
        vt.push_back(mk(2'b01, 0, 11, 1, 0, 12, K_LOAD, 0, 0, 0, 0, 32'h0));
        vt.push_back(mk(2'b01, 0, 12, 0, 0, 0, K_ALU,  0, 0,  0, 0, 32'h0));

        // Reset state, sampled while reset is still asserted.
        rst_n = 1'b0;
        drive(2'b11, 5, 6, 1'b0, 1'b0, 0, K_ALU, 1'b0, 0, 1'b0);
        #12;
        chk("reset_stall", 32'(stall), 32'h0);
        chk("reset_pend", pend_mask, 32'h0);
        rst_n = 1'b1;

        // Table: inputs held for one cycle; outputs checked mid-cycle before the edge.
        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].en, int'(vt[i].s1), int'(vt[i].s0), vt[i].fire, vt[i].we,
                  int'(vt[i].rd), vt[i].kind, vt[i].wbv, int'(vt[i].wbrd), vt[i].fl);
            @(negedge clk);
            chk($sformatf("row%0d_stall", i), 32'(stall), 32'(vt[i].es));
            chk($sformatf("row%0d_pend", i), pend_mask, vt[i].ep);
            @(posedge clk); #1;
        end

        // Long op x13: stall for the 15 cycles up to and including the wb cycle, then clear.
        drive(2'b01, 0, 13, 1'b1, 1'b1, 13, K_LONG, 1'b0, 0, 1'b0);
        @(negedge clk);
        chk("long_issue_stall", 32'(stall), 32'h0);
        @(posedge clk); #1;
        for (int k = 1; k <= 15; k++) begin
            drive(2'b01, 0, 13, 1'b0, 1'b0, 0, K_ALU, (k == 15), 13, 1'b0);
            @(negedge clk);
            chk($sformatf("long_c%0d_stall", k), 32'(stall), 32'h1);
            chk($sformatf("long_c%0d_pend13", k), 32'(pend_mask[13]), 32'h1);
            @(posedge clk); #1;
        end
        idle_src(13);
        @(negedge clk);
        chk("long_done_stall", 32'(stall), 32'h0);
        chk("long_done_pend", pend_mask, 32'h0);
        @(posedge clk); #1;

        // Reset mid-operation with a load and a long op in flight.
        drive(2'b01, 0, 5, 1'b1, 1'b1, 5, K_LOAD, 1'b0, 0, 1'b0);
        @(posedge clk); #1;
        drive(2'b11, 6, 5, 1'b1, 1'b1, 6, K_LONG, 1'b0, 0, 1'b0);
        @(posedge clk); #1;
        drive(2'b11, 6, 5, 1'b0, 1'b0, 0, K_ALU, 1'b0, 0, 1'b0);
        @(negedge clk);
        chk("midrst_before_pend", pend_mask, 32'h60);
        chk("midrst_before_stall", 32'(stall), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_in_pend", pend_mask, 32'h0);
        chk("midrst_in_stall", 32'(stall), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(2'b11, 6, 5, 1'b0, 1'b0, 0, K_ALU, 1'b1, 6, 1'b0);
        @(negedge clk);
        chk("midrst_first_pend", pend_mask, 32'h0);
        chk("midrst_first_stall", 32'(stall), 32'h0);
        @(posedge clk); #1;
        drive(2'b11, 6, 5, 1'b0, 1'b0, 0, K_ALU, 1'b0, 0, 1'b0);
        @(negedge clk);
        chk("midrst_after_pend", pend_mask, 32'h0);
        chk("midrst_after_stall", 32'(stall), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
